// File: rtl/memory_bus_ctrl.sv
// -----------------------------------------------------------------------------
// memory_bus_ctrl
//
// Sequences single memory requests from the Z8 core's external memory port
// onto a 2k program ROM and an 8k data RAM. Both memories have a registered
// read port.
//
// Each request passes through IDLE -> STROBE -> WAIT -> RESP -> IDLE:
//   - a one-cycle strobe is issued to the selected memory,
//   - the controller then waits waitStates+1 cycles,
//   - the response is returned as a one-cycle rspValid pulse.
//
// Parameters:
//   waitStates  extra cycles between strobe and data capture (0..15)
//   ramBase     8k-aligned base address of the RAM window
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   reqValid/reqReady             request handshake
//   reqWrite/reqAddr/reqData      request attributes (sampled on handshake)
//   rspValid/rspData              one-cycle response pulse and held data
//   romAddr/romStrobe/romData     program ROM port
//   ramAddr/ramDataIn/ramWrite/
//   ramStrobe/ramData             data RAM port
//   fault                         sticky illegal-access flag
//
// Optional feature: define MEMBUS_FAULT_EN to make fault latch on ROM writes
// and unmapped accesses. When the macro is undefined, fault is tied low and
// illegal accesses still complete with rspData 8'hFF.
// -----------------------------------------------------------------------------
module memory_bus_ctrl #(
    parameter int unsigned waitStates = 0,
    parameter logic [15:0] ramBase    = 16'h8000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqValid,
    input  logic        reqWrite,
    input  logic [15:0] reqAddr,
    input  logic [7:0]  reqData,
    output logic        reqReady,
    output logic        rspValid,
    output logic [7:0]  rspData,
    output logic [10:0] romAddr,
    output logic        romStrobe,
    input  logic [7:0]  romData,
    output logic [12:0] ramAddr,
    output logic [7:0]  ramDataIn,
    output logic        ramWrite,
    output logic        ramStrobe,
    input  logic [7:0]  ramData,
    output logic        fault
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STROBE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(waitStates);
    localparam logic [2:0] RAM_PAGE  = ramBase[15:13];

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        romRd_q;     // latched: mapped ROM read
    logic        ramAcc_q;    // latched: mapped RAM read or write
    logic        rspValid_q;
    logic [7:0]  rspData_q;
    logic [10:0] romAddr_q;
    logic        romStrobe_q;
    logic [12:0] ramAddr_q;
    logic [7:0]  ramDataIn_q;
    logic        ramWrite_q;
    logic        ramStrobe_q;

    // ROM wins any overlap, so a badly chosen ramBase cannot double-select.
    logic hitRom;
    logic hitRam;
    assign hitRom = (reqAddr[15:11] == 5'd0);
    assign hitRam = !hitRom && (reqAddr[15:13] == RAM_PAGE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            romRd_q     <= 1'b0;
            ramAcc_q    <= 1'b0;
            rspValid_q  <= 1'b0;
            rspData_q   <= 8'h00;
            romAddr_q   <= 11'd0;
            romStrobe_q <= 1'b0;
            ramAddr_q   <= 13'd0;
            ramDataIn_q <= 8'h00;
            ramWrite_q  <= 1'b0;
            ramStrobe_q <= 1'b0;
        end else begin
            // Pulse outputs default low; each is raised for exactly one cycle.
            rspValid_q  <= 1'b0;
            romStrobe_q <= 1'b0;
            ramStrobe_q <= 1'b0;
            ramWrite_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (reqValid) begin
                        romAddr_q   <= reqAddr[10:0];
                        ramAddr_q   <= reqAddr[12:0];
                        ramDataIn_q <= reqData;
                        romRd_q     <= hitRom && !reqWrite;
                        ramAcc_q    <= hitRam;
                        // Strobes are registered here so they are high
                        // exactly during the STROBE state.
                        romStrobe_q <= hitRom && !reqWrite;
                        ramStrobe_q <= hitRam;
                        ramWrite_q  <= hitRam && reqWrite;
                        state_q     <= S_STROBE;
                    end
                end
                S_STROBE: begin
                    cnt_q   <= 4'd0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q == WAIT_LAST) begin
                        // RAM echoes write data on its read port, so both
                        // RAM reads and writes capture ramData.
                        if (romRd_q) begin
                            rspData_q <= romData;
                        end else if (ramAcc_q) begin
                            rspData_q <= ramData;
                        end else begin
                            rspData_q <= 8'hFF;
                        end
                        rspValid_q <= 1'b1;
                        state_q    <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MEMBUS_FAULT_EN
    logic fault_q;

    // Set on the edge entering RESP so fault is already high in the RESP cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else if (state_q == S_WAIT && cnt_q == WAIT_LAST &&
                     !romRd_q && !ramAcc_q) begin
            fault_q <= 1'b1;
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign reqReady  = (state_q == S_IDLE) && !reset;
    assign rspValid  = rspValid_q;
    assign rspData   = rspData_q;
    assign romAddr   = romAddr_q;
    assign romStrobe = romStrobe_q;
    assign ramAddr   = ramAddr_q;
    assign ramDataIn = ramDataIn_q;
    assign ramWrite  = ramWrite_q;
    assign ramStrobe = ramStrobe_q;

endmodule

// File: tb/tb_memory_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_memory_bus_ctrl
//
// Directed bench for memory_bus_ctrl. It uses two instances:
//   - dut0 with waitStates = 0
//   - dut3 with waitStates = 3
// Each instance has its own behavioural ROM/RAM with a registered read port.
// The RAM echoes write data on its read port.
// ROM contents are rom[i] = i ^ 8'h39, so rom[5] = 8'h3C.
// -----------------------------------------------------------------------------
module tb_memory_bus_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] rom [0:2047];
    logic [7:0] ramA [0:8191];
    logic [7:0] ramB [0:8191];

    // dut0 signals
    logic        a_reqValid = 1'b0, a_reqWrite = 1'b0;
    logic [15:0] a_reqAddr = 16'h0;
    logic [7:0]  a_reqData = 8'h0;
    logic        a_reqReady, a_rspValid, a_romStrobe, a_ramWrite, a_ramStrobe, a_fault;
    logic [7:0]  a_rspData, a_romData, a_ramDataIn, a_ramData;
    logic [10:0] a_romAddr;
    logic [12:0] a_ramAddr;

    // dut3 signals
    logic        b_reqValid = 1'b0, b_reqWrite = 1'b0;
    logic [15:0] b_reqAddr = 16'h0;
    logic [7:0]  b_reqData = 8'h0;
    logic        b_reqReady, b_rspValid, b_romStrobe, b_ramWrite, b_ramStrobe, b_fault;
    logic [7:0]  b_rspData, b_romData, b_ramDataIn, b_ramData;
    logic [10:0] b_romAddr;
    logic [12:0] b_ramAddr;

    logic expFault;

    memory_bus_ctrl #(.waitStates(0), .ramBase(16'h8000)) dut0 (
        .clk(clk), .reset(reset),
        .reqValid(a_reqValid), .reqWrite(a_reqWrite), .reqAddr(a_reqAddr),
        .reqData(a_reqData), .reqReady(a_reqReady),
        .rspValid(a_rspValid), .rspData(a_rspData),
        .romAddr(a_romAddr), .romStrobe(a_romStrobe), .romData(a_romData),
        .ramAddr(a_ramAddr), .ramDataIn(a_ramDataIn), .ramWrite(a_ramWrite),
        .ramStrobe(a_ramStrobe), .ramData(a_ramData), .fault(a_fault)
    );

    memory_bus_ctrl #(.waitStates(3), .ramBase(16'h8000)) dut3 (
        .clk(clk), .reset(reset),
        .reqValid(b_reqValid), .reqWrite(b_reqWrite), .reqAddr(b_reqAddr),
        .reqData(b_reqData), .reqReady(b_reqReady),
        .rspValid(b_rspValid), .rspData(b_rspData),
        .romAddr(b_romAddr), .romStrobe(b_romStrobe), .romData(b_romData),
        .ramAddr(b_ramAddr), .ramDataIn(b_ramDataIn), .ramWrite(b_ramWrite),
        .ramStrobe(b_ramStrobe), .ramData(b_ramData), .fault(b_fault)
    );

    // Behavioural memories with registered read ports.
    always @(posedge clk) begin
        if (a_romStrobe) a_romData <= rom[a_romAddr];
        if (a_ramStrobe) begin
            if (a_ramWrite) begin
                ramA[a_ramAddr] <= a_ramDataIn;
                a_ramData <= a_ramDataIn;
            end else begin
                a_ramData <= ramA[a_ramAddr];
            end
        end
        if (b_romStrobe) b_romData <= rom[b_romAddr];
        if (b_ramStrobe) begin
            if (b_ramWrite) begin
                ramB[b_ramAddr] <= b_ramDataIn;
                b_ramData <= b_ramDataIn;
            end else begin
                b_ramData <= ramB[b_ramAddr];
            end
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef MEMBUS_FAULT_EN
        expFault = 1'b1;
`else
        expFault = 1'b0;
`endif
        for (int i = 0; i < 2048; i++) rom[i] = 8'(i) ^ 8'h39;
        for (int i = 0; i < 8192; i++) begin
            ramA[i] = 8'h00;
            ramB[i] = 8'h00;
        end
        ramB[13'h1FFF] = 8'h5E;
        a_romData = 8'h00; a_ramData = 8'h00;
        b_romData = 8'h00; b_ramData = 8'h00;

        // Reset
        tick(); tick();
        chk("ready_in_reset", {15'd0, a_reqReady}, 16'd0);
        reset = 1'b0;
        #1;
        chk("rst_ready", {15'd0, a_reqReady}, 16'd1);
        chk("rst_rspValid", {15'd0, a_rspValid}, 16'd0);
        chk("rst_rspData", {8'd0, a_rspData}, 16'h0000);
        chk("rst_strobes", {13'd0, a_romStrobe, a_ramStrobe, a_ramWrite}, 16'd0);
        chk("rst_addr", {5'd0, a_romAddr}, 16'd0);
        chk("rst_ramAddr", {3'd0, a_ramAddr}, 16'd0);
        chk("rst_fault", {15'd0, a_fault}, 16'd0);

        // ROM read 0x0005, waitStates 0 (cycle T)
        a_reqValid = 1'b1; a_reqWrite = 1'b0; a_reqAddr = 16'h0005;
        tick();                                    // T+1
        a_reqValid = 1'b0;
        chk("rd5_romStrobe_T1", {15'd0, a_romStrobe}, 16'd1);
        chk("rd5_ramStrobe_T1", {15'd0, a_ramStrobe}, 16'd0);
        chk("rd5_ready_T1", {15'd0, a_reqReady}, 16'd0);
        tick();                                    // T+2
        chk("rd5_romStrobe_T2", {15'd0, a_romStrobe}, 16'd0);
        chk("rd5_rspValid_T2", {15'd0, a_rspValid}, 16'd0);
        tick();                                    // T+3
        chk("rd5_rspValid_T3", {15'd0, a_rspValid}, 16'd1);
        chk("rd5_rspData", {8'd0, a_rspData}, 16'h003C);
        chk("rd5_ramStrobe_T3", {15'd0, a_ramStrobe}, 16'd0);
        tick();                                    // T+4
        chk("rd5_rspValid_T4", {15'd0, a_rspValid}, 16'd0);
        chk("rd5_ready_T4", {15'd0, a_reqReady}, 16'd1);
        chk("rd5_data_held", {8'd0, a_rspData}, 16'h003C);

        // RAM write 8'hA5 to 0x8010, then read it back
        a_reqValid = 1'b1; a_reqWrite = 1'b1; a_reqAddr = 16'h8010; a_reqData = 8'hA5;
        tick();
        a_reqValid = 1'b0;
        chk("wr_ramStrobe", {15'd0, a_ramStrobe}, 16'd1);
        chk("wr_ramWrite", {15'd0, a_ramWrite}, 16'd1);
        chk("wr_romStrobe", {15'd0, a_romStrobe}, 16'd0);
        chk("wr_ramAddr", {3'd0, a_ramAddr}, 16'h0010);
        chk("wr_ramDataIn", {8'd0, a_ramDataIn}, 16'h00A5);
        tick(); tick();
        chk("wr_rspValid", {15'd0, a_rspValid}, 16'd1);
        chk("wr_echo", {8'd0, a_rspData}, 16'h00A5);
        tick();
        a_reqValid = 1'b1; a_reqWrite = 1'b0; a_reqData = 8'h00;
        tick();
        a_reqValid = 1'b0;
        chk("rdram_ramStrobe", {15'd0, a_ramStrobe}, 16'd1);
        chk("rdram_ramWrite", {15'd0, a_ramWrite}, 16'd0);
        tick(); tick();
        chk("rdram_rspValid", {15'd0, a_rspValid}, 16'd1);
        chk("rdram_data", {8'd0, a_rspData}, 16'h00A5);
        tick();

        // ROM write 0x0100: illegal, no strobe, 8'hFF
        a_reqValid = 1'b1; a_reqWrite = 1'b1; a_reqAddr = 16'h0100; a_reqData = 8'h12;
        tick();
        a_reqValid = 1'b0;
        chk("romwr_strobes", {13'd0, a_romStrobe, a_ramStrobe, a_ramWrite}, 16'd0);
        tick(); tick();
        chk("romwr_rspValid", {15'd0, a_rspValid}, 16'd1);
        chk("romwr_data", {8'd0, a_rspData}, 16'h00FF);
        chk("romwr_fault", {15'd0, a_fault}, {15'd0, expFault});
        tick();
        // ROM read 0x0003 in between so the next 8'hFF is freshly captured
        a_reqValid = 1'b1; a_reqWrite = 1'b0; a_reqAddr = 16'h0003;
        tick(); a_reqValid = 1'b0; tick(); tick();
        chk("rd3_data", {8'd0, a_rspData}, 16'h003A);
        tick();
        // Unmapped read 0x4000
        a_reqValid = 1'b1; a_reqWrite = 1'b0; a_reqAddr = 16'h4000;
        tick();
        a_reqValid = 1'b0;
        chk("unmap_strobes", {13'd0, a_romStrobe, a_ramStrobe, a_ramWrite}, 16'd0);
        tick(); tick();
        chk("unmap_rspValid", {15'd0, a_rspValid}, 16'd1);
        chk("unmap_data", {8'd0, a_rspData}, 16'h00FF);
        chk("unmap_fault", {15'd0, a_fault}, {15'd0, expFault});
        tick();

        // Reset during WAIT of a RAM read
        a_reqValid = 1'b1; a_reqWrite = 1'b0; a_reqAddr = 16'h8010;
        tick();                                    // STROBE
        a_reqValid = 1'b0;
        tick();                                    // WAIT
        reset = 1'b1;
        tick();
        chk("abort_rspValid", {15'd0, a_rspValid}, 16'd0);
        chk("abort_rspData", {8'd0, a_rspData}, 16'h0000);
        chk("abort_strobes", {13'd0, a_romStrobe, a_ramStrobe, a_ramWrite}, 16'd0);
        chk("abort_fault", {15'd0, a_fault}, 16'd0);
        reset = 1'b0;
        #1;
        chk("abort_ready", {15'd0, a_reqReady}, 16'd1);
        tick();
        chk("abort_no_rsp", {15'd0, a_rspValid}, 16'd0);
        chk("abort_ram_kept", {8'd0, ramA[13'h0010]}, 16'h00A5);

        // Back-to-back ROM reads with reqValid held high, waitStates 0
        a_reqValid = 1'b1; a_reqWrite = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_reqAddr = 16'(i);
            chk($sformatf("b2b%0d_ready_T", i), {15'd0, a_reqReady}, 16'd1);
            tick();
            chk($sformatf("b2b%0d_ready_T1", i), {15'd0, a_reqReady}, 16'd0);
            chk($sformatf("b2b%0d_rsp_T1", i), {15'd0, a_rspValid}, 16'd0);
            tick();
            chk($sformatf("b2b%0d_rsp_T2", i), {15'd0, a_rspValid}, 16'd0);
            tick();
            chk($sformatf("b2b%0d_rsp_T3", i), {15'd0, a_rspValid}, 16'd1);
            chk($sformatf("b2b%0d_data", i), {8'd0, a_rspData}, {8'd0, 8'(i) ^ 8'h39});
            tick();
        end
        a_reqValid = 1'b0;

        // waitStates 3: read 0x9FFF
        b_reqValid = 1'b1; b_reqWrite = 1'b0; b_reqAddr = 16'h9FFF;
        chk("ws3_ready_T", {15'd0, b_reqReady}, 16'd1);
        tick();                                    // T+1
        b_reqValid = 1'b0;
        chk("ws3_ramStrobe", {15'd0, b_ramStrobe}, 16'd1);
        chk("ws3_ramAddr", {3'd0, b_ramAddr}, 16'h1FFF);
        chk("ws3_ready_T1", {15'd0, b_reqReady}, 16'd0);
        for (int c = 2; c <= 5; c++) begin
            tick();
            chk($sformatf("ws3_ready_T%0d", c), {15'd0, b_reqReady}, 16'd0);
            chk($sformatf("ws3_rsp_T%0d", c), {15'd0, b_rspValid}, 16'd0);
            chk($sformatf("ws3_strobe_T%0d", c), {15'd0, b_ramStrobe}, 16'd0);
        end
        tick();                                    // T+6
        chk("ws3_rspValid_T6", {15'd0, b_rspValid}, 16'd1);
        chk("ws3_data", {8'd0, b_rspData}, 16'h005E);
        chk("ws3_ready_T6", {15'd0, b_reqReady}, 16'd0);
        tick();                                    // T+7
        chk("ws3_rspValid_T7", {15'd0, b_rspValid}, 16'd0);
        chk("ws3_ready_T7", {15'd0, b_reqReady}, 16'd1);

        // waitStates 3: held reqValid, responses every 7 cycles
        b_reqValid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            b_reqAddr = 16'h0010 + 16'(i);
            tick();
            for (int c = 1; c < 6; c++) tick();
            chk($sformatf("ws3b2b%0d_rsp", i), {15'd0, b_rspValid}, 16'd1);
            chk($sformatf("ws3b2b%0d_data", i), {8'd0, b_rspData},
                {8'd0, (8'h10 + 8'(i)) ^ 8'h39});
            tick();
            chk($sformatf("ws3b2b%0d_ready", i), {15'd0, b_reqReady}, 16'd1);
        end
        b_reqValid = 1'b0;
        chk("ws3_fault", {15'd0, b_fault}, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
